md5_seq_ctrl: RTL and testbench
===============================

MD5_SEQ_CTRL -- requirements
Module: md5_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the maximum cycles spent in WAIT before abort.
REQ-002 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 wb_rst_i  in  1  asynchronous reset, active-high.
REQ-004 word_valid_i  in  1  message word offered.
REQ-005 word_data_i  in  32  message word; word k of a block lands in core_msg_padded_o[32k+31:32k].
REQ-006 word_ready_o  out  1  word accepted when word_valid_i & word_ready_o.
REQ-007 core_msg_padded_o  out  512  assembled block to MD5 core.
REQ-008 core_msg_in_valid_o  out  1  single-cycle issue pulse to core.
REQ-009 core_ready_i  in  1  core able to accept a block.
REQ-010 core_msg_output_i  in  128  digest from core.
REQ-011 core_msg_out_valid_i  in  1  digest valid strobe from core.
REQ-012 hash_o  out  128  captured digest.
REQ-013 hash_valid_o  out  1  digest held, awaiting ack.
REQ-014 hash_ack_i  in  1  consumer releases digest.
REQ-015 busy_o  out  1  high in any state except LOAD with word count 0.
REQ-016 timeout_o  out  1  one-cycle abort pulse (present only with MD5_SEQ_TIMEOUT_EN).

Function
REQ-017 FSM states SHALL be LOAD, ISSUE, WAIT, DONE.
REQ-018 LOAD: word_ready_o=1; each accepted word written to slot word_cnt, word_cnt increments (5-bit, 0..15).
REQ-019 LOAD: acceptance of the 16th word (word_cnt=15) SHALL move to ISSUE next cycle and clear word_cnt.
REQ-020 word_ready_o SHALL be 0 outside LOAD; offered words there are ignored, buffer unchanged.
REQ-021 ISSUE: while core_ready_i=0 hold; first cycle with core_ready_i=1 SHALL assert core_msg_in_valid_o for exactly that cycle (registered) and enter WAIT.
REQ-022 core_msg_padded_o SHALL remain stable from entering ISSUE until leaving WAIT.
REQ-023 WAIT: core_msg_out_valid_i=1 SHALL load hash_o from core_msg_output_i and enter DONE; strobes in LOAD/ISSUE/DONE ignored.
REQ-024 DONE: hash_valid_o=1; hash_ack_i=1 SHALL return to LOAD next cycle, hash_valid_o low that cycle.
REQ-025 hash_o SHALL hold its value until the next capture (not cleared on ack).
REQ-026 hash_ack_i outside DONE SHALL have no effect.
REQ-027 Latency: last word accepted at cycle t, core_ready_i high -> core_msg_in_valid_o at t+2; digest strobe at u -> hash_valid_o at u+1.

Reset
REQ-028 Reset mid-operation SHALL abort immediately: state LOAD, word_cnt 0, buffer 0.
REQ-029 Reset values: core_msg_padded_o 0, core_msg_in_valid_o 0, hash_o 0, hash_valid_o 0, timeout_o 0, word_ready_o 1, busy_o 0.

Configuration
REQ-030 Macro MD5_SEQ_TIMEOUT_EN defined: 16-bit counter cleared on WAIT entry, increments each WAIT cycle; reaching TIMEOUT_CYCLES-1 without strobe SHALL pulse timeout_o one cycle, return to LOAD, leave hash_o/hash_valid_o unchanged.
REQ-031 Strobe and terminal count in same cycle: strobe wins, no timeout.
REQ-032 Macro undefined: no counter, no timeout_o port, WAIT held indefinitely.

Structure
REQ-033 Shared package md5_seq_pkg SHALL hold state encoding, BLOCK_WORDS=16, WORD_W=32, DIGEST_W=128.
REQ-034 Sub-module md5_block_buf (16x32 word buffer, indexed write, flat 512-bit read, clear) SHALL be instantiated once.

Verification
REQ-035 Load words 0x00000000..0x0000000F, core_ready_i=1 -> core_msg_padded_o[31:0]=0, [511:480]=0xF, issue pulse at t+2 width 1.
REQ-036 core_ready_i held 0 for 10 cycles after block -> no pulse, state ISSUE, word_ready_o=0; raise -> pulse next cycle.
REQ-037 Strobe with 0x0123456789ABCDEFFEDCBA9876543210 -> hash_o matches, hash_valid_o=1 until ack, then LOAD accepts new words.
REQ-038 Reset asserted after 7 words -> word_cnt 0, buffer 0, next 16 words form a fresh block.
REQ-039 With MD5_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, no strobe -> timeout_o pulse 8th WAIT cycle, hash_valid_o stays 0; strobe on same cycle -> DONE, no pulse.

Source files
------------

// File: rtl/md5_seq_pkg.sv
// rtl/md5_seq_pkg.sv - shared constants and state encoding for the MD5 block sequencer
package md5_seq_pkg;

   localparam int BLOCK_WORDS = 16;
   localparam int WORD_W      = 32;
   localparam int DIGEST_W    = 128;
   localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/md5_seq_ctrl_if.sv
// rtl/md5_seq_ctrl_if.sv - word input, core and digest signals of md5_seq_ctrl (timeout_o only with MD5_SEQ_TIMEOUT_EN)
interface md5_seq_ctrl_if;
   import md5_seq_pkg::*;

   logic                word_valid_i;
   logic [WORD_W-1:0]   word_data_i;
   logic                word_ready_o;
   logic [BLOCK_W-1:0]  core_msg_padded_o;
   logic                core_msg_in_valid_o;
   logic                core_ready_i;
   logic [DIGEST_W-1:0] core_msg_output_i;
   logic                core_msg_out_valid_i;
   logic [DIGEST_W-1:0] hash_o;
   logic                hash_valid_o;
   logic                hash_ack_i;
   logic                busy_o;
`ifdef MD5_SEQ_TIMEOUT_EN
   logic                timeout_o;
`endif

   // Sequencer side
   modport slave (
      input  word_valid_i, word_data_i, core_ready_i, core_msg_output_i,
             core_msg_out_valid_i, hash_ack_i,
      output word_ready_o, core_msg_padded_o, core_msg_in_valid_o, hash_o,
             hash_valid_o, busy_o
`ifdef MD5_SEQ_TIMEOUT_EN
      , output timeout_o
`endif
   );

   // Word producer, MD5 core and digest consumer side
   modport master (
      output word_valid_i, word_data_i, core_ready_i, core_msg_output_i,
             core_msg_out_valid_i, hash_ack_i,
      input  word_ready_o, core_msg_padded_o, core_msg_in_valid_o, hash_o,
             hash_valid_o, busy_o
`ifdef MD5_SEQ_TIMEOUT_EN
      , input timeout_o
`endif
   );

endinterface

// File: rtl/md5_block_buf.sv
// rtl/md5_block_buf.sv - 16x32 message word buffer with indexed write, flat 512-bit read, clear on reset
module md5_block_buf
   import md5_seq_pkg::*;
(
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                we,
   input  logic [3:0]          waddr,
   input  logic [WORD_W-1:0]   wdata,
   output logic [BLOCK_W-1:0]  block
);

   logic [WORD_W-1:0] mem [BLOCK_WORDS];

   // Word storage; reset wipes the whole block so an aborted load leaves nothing behind
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Word k lands in bits [32k+31:32k] of the flat block
   always_comb begin
      block = '0;
      for (int i = 0; i < BLOCK_WORDS; i++) block[i*WORD_W +: WORD_W] = mem[i];
   end

endmodule

// File: rtl/md5_seq_ctrl.sv
// rtl/md5_seq_ctrl.sv - gathers 16 words into a block, issues it to the MD5 core, holds the digest until acked (WAIT timeout under MD5_SEQ_TIMEOUT_EN)
module md5_seq_ctrl
   import md5_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   md5_seq_ctrl_if.slave bus
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_cfg_check
      $error("md5_seq_ctrl: TIMEOUT_CYCLES must lie in 2..65536");
   end

   seq_state_e          state_q, state_d;
   logic [4:0]          word_cnt_q, word_cnt_d;
   logic                in_valid_q;
   logic [DIGEST_W-1:0] hash_q;
   logic                accept;
   logic                issue;
   logic                capture;
   logic                timeout_hit;

   assign accept = (state_q == ST_LOAD) && bus.word_valid_i;

   md5_block_buf u_buf (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .we       (accept),
      .waddr    (word_cnt_q[3:0]),
      .wdata    (bus.word_data_i),
      .block    (bus.core_msg_padded_o)
   );

`ifdef MD5_SEQ_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_cnt_q;

   // WAIT cycle counter: held at zero while issuing so the first WAIT cycle counts as 0
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)                to_cnt_q <= '0;
      else if (state_q == ST_ISSUE) to_cnt_q <= '0;
      else if (state_q == ST_WAIT)  to_cnt_q <= to_cnt_q + 16'd1;
   end

   assign bus.timeout_o = timeout_hit;
`endif

   // Next-state logic; a digest strobe takes priority over the timeout terminal count
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      issue       = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            if (accept) begin
               if (word_cnt_q == 5'd15) begin
                  word_cnt_d = '0;
                  state_d    = ST_ISSUE;
               end else begin
                  word_cnt_d = word_cnt_q + 5'd1;
               end
            end
         end
         ST_ISSUE: begin
            if (bus.core_ready_i) begin
               issue   = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.core_msg_out_valid_i) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
`ifdef MD5_SEQ_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               timeout_hit = 1'b1;
               state_d     = ST_LOAD;
            end
`endif
         end
         ST_DONE: begin
            if (bus.hash_ack_i) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // State, word count, registered issue pulse and captured digest
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_LOAD;
         word_cnt_q <= '0;
         in_valid_q <= 1'b0;
         hash_q     <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         in_valid_q <= issue;
         if (capture) hash_q <= bus.core_msg_output_i;
      end
   end

   assign bus.word_ready_o        = (state_q == ST_LOAD);
   assign bus.core_msg_in_valid_o = in_valid_q;
   assign bus.hash_o              = hash_q;
   assign bus.hash_valid_o        = (state_q == ST_DONE);
   assign bus.busy_o              = !((state_q == ST_LOAD) && (word_cnt_q == 5'd0));

endmodule

// File: tb/tb_md5_seq_ctrl.sv
// tb/tb_md5_seq_ctrl.sv - self-checking bench for md5_seq_ctrl (timeout checks with MD5_SEQ_TIMEOUT_EN)
module tb_md5_seq_ctrl;

   localparam int TO = 8;
   localparam logic [127:0] DIG = 128'h0123456789ABCDEFFEDCBA9876543210;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   md5_seq_ctrl_if bus();

   md5_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: 0 collecting words, 1 block waiting for core, 2 core hashing, 3 digest held
   int           m_phase;
   int           m_cnt;
   int           m_wcyc;
   logic [31:0]  m_blk [16];
   logic [127:0] m_hash;
   bit           m_pulse;

   task automatic cmp(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] m_block();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = m_blk[i];
      return r;
   endfunction

   task automatic m_reset();
      m_phase = 0; m_cnt = 0; m_wcyc = 0; m_hash = '0; m_pulse = 1'b0;
      for (int i = 0; i < 16; i++) m_blk[i] = '0;
   endtask

   function automatic bit m_timeout();
`ifdef MD5_SEQ_TIMEOUT_EN
      return (m_phase == 2) && (m_wcyc == TO - 1) && !bus.core_msg_out_valid_i;
`else
      return 1'b0;
`endif
   endfunction

   // One clock: compare at the falling edge, advance the model, return just after the rising edge
   task automatic cycle();
      bit to;
      @(negedge clk);
      if (rst) m_reset();
      to = m_timeout();
      cmp("word_ready", bus.word_ready_o, m_phase == 0);
      cmp("busy", bus.busy_o, !(m_phase == 0 && m_cnt == 0));
      cmp("padded", bus.core_msg_padded_o, m_block());
      cmp("in_valid", bus.core_msg_in_valid_o, m_pulse);
      cmp("hash_valid", bus.hash_valid_o, m_phase == 3);
      cmp("hash", bus.hash_o, m_hash);
`ifdef MD5_SEQ_TIMEOUT_EN
      cmp("timeout", bus.timeout_o, to);
`endif
      if (!rst) begin
         m_pulse = 1'b0;
         case (m_phase)
            0: if (bus.word_valid_i) begin
                  m_blk[m_cnt] = bus.word_data_i;
                  if (m_cnt == 15) begin m_cnt = 0; m_phase = 1; end
                  else m_cnt++;
               end
            1: if (bus.core_ready_i) begin m_pulse = 1'b1; m_phase = 2; m_wcyc = 0; end
            2: if (bus.core_msg_out_valid_i) begin m_hash = bus.core_msg_output_i; m_phase = 3; end
               else if (to) m_phase = 0;
               else m_wcyc++;
            3: if (bus.hash_ack_i) m_phase = 0;
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_block(input logic [31:0] base, input logic rdy);
      for (int k = 0; k < 16; k++) begin
         bus.word_valid_i = 1'b1;
         bus.word_data_i  = base + 32'(k);
         bus.core_ready_i = rdy;
         cycle();
      end
      bus.word_valid_i = 1'b0;
   endtask

   task automatic finish_hash();
      bus.core_msg_out_valid_i = 1'b1;
      bus.core_msg_output_i    = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      bus.core_msg_out_valid_i = 1'b0;
      bus.hash_ack_i = 1'b1;
      cycle();
      bus.hash_ack_i = 1'b0;
   endtask

   initial begin
      bus.word_valid_i = 1'b0; bus.word_data_i = '0; bus.core_ready_i = 1'b0;
      bus.core_msg_output_i = '0; bus.core_msg_out_valid_i = 1'b0; bus.hash_ack_i = 1'b0;
      m_reset();
      #1;
      cmp("rst_word_ready", bus.word_ready_o, 1);
      cmp("rst_busy", bus.busy_o, 0);
      cmp("rst_padded", bus.core_msg_padded_o, 0);
      cmp("rst_hash_valid", bus.hash_valid_o, 0);
      cycle();
      rst = 1'b0;

      // Incrementing block with the core ready: issue pulse two cycles after the last word
      load_block(32'h0, 1'b1);
      cmp("035_no_pulse_t1", bus.core_msg_in_valid_o, 0);
      cycle();
      cmp("035_pulse_t2", bus.core_msg_in_valid_o, 1);
      cmp("035_word0", bus.core_msg_padded_o[31:0], 32'h0);
      cmp("035_word15", bus.core_msg_padded_o[511:480], 32'hF);
      cycle();
      cmp("035_pulse_width", bus.core_msg_in_valid_o, 0);
      bus.core_ready_i = 1'b0;

      // Digest capture, hold until ack, then LOAD again
      bus.core_msg_out_valid_i = 1'b1;
      bus.core_msg_output_i    = DIG;
      cycle();
      bus.core_msg_out_valid_i = 1'b0;
      bus.core_msg_output_i    = '0;
      cmp("037_hash", bus.hash_o, DIG);
      cmp("037_valid", bus.hash_valid_o, 1);
      repeat (3) cycle();
      cmp("037_valid_hold", bus.hash_valid_o, 1);
      bus.hash_ack_i = 1'b1;
      cycle();
      bus.hash_ack_i = 1'b0;
      cmp("037_valid_after_ack", bus.hash_valid_o, 0);
      cmp("037_ready_after_ack", bus.word_ready_o, 1);
      cmp("037_hash_kept", bus.hash_o, DIG);

      // Core not ready for 10 cycles; extra word offers must be ignored
      load_block(32'h100, 1'b0);
      bus.word_valid_i = 1'b1;
      bus.word_data_i  = 32'hDEAD_BEEF;
      repeat (10) cycle();
      bus.word_valid_i = 1'b0;
      cmp("036_no_pulse", bus.core_msg_in_valid_o, 0);
      cmp("036_ready_low", bus.word_ready_o, 0);
      bus.core_ready_i = 1'b1;
      cycle();
      bus.core_ready_i = 1'b0;
      cmp("036_pulse", bus.core_msg_in_valid_o, 1);
      cmp("036_word3", bus.core_msg_padded_o[127:96], 32'h103);
      finish_hash();

      // Reset after 7 words, then a fresh block
      for (int k = 0; k < 7; k++) begin
         bus.word_valid_i = 1'b1;
         bus.word_data_i  = $urandom;
         cycle();
      end
      bus.word_valid_i = 1'b0;
      cmp("038_busy_partial", bus.busy_o, 1);
      rst = 1'b1;
      #1;
      cmp("038_rst_padded", bus.core_msg_padded_o, 0);
      cmp("038_rst_busy", bus.busy_o, 0);
      cycle();
      rst = 1'b0;
      load_block(32'hA0, 1'b0);
      cmp("038_word0", bus.core_msg_padded_o[31:0], 32'hA0);
      cmp("038_word1", bus.core_msg_padded_o[63:32], 32'hA1);
      bus.core_ready_i = 1'b1;
      cycle();
      bus.core_ready_i = 1'b0;
      finish_hash();

`ifdef MD5_SEQ_TIMEOUT_EN
      // No strobe: abort pulse in the 8th WAIT cycle
      load_block(32'h200, 1'b1);
      cycle();
      for (int i = 1; i <= 8; i++) begin
         cmp("039_timeout", bus.timeout_o, i == 8);
         cycle();
      end
      cmp("039_back_to_load", bus.word_ready_o, 1);
      cmp("039_no_hash_valid", bus.hash_valid_o, 0);
      // Strobe on the terminal cycle wins
      load_block(32'h300, 1'b1);
      cycle();
      repeat (7) cycle();
      bus.core_msg_out_valid_i = 1'b1;
      bus.core_msg_output_i    = DIG;
      cmp("039_strobe_wins", bus.timeout_o, 0);
      cycle();
      bus.core_msg_out_valid_i = 1'b0;
      cmp("039_done", bus.hash_valid_o, 1);
      bus.hash_ack_i = 1'b1;
      cycle();
      bus.hash_ack_i = 1'b0;
`endif
      bus.core_ready_i = 1'b0;

      // Randomized traffic checked against the model every cycle
      repeat (3000) begin
         rst                      = ($urandom_range(0, 499) == 0);
         bus.word_valid_i         = 1'($urandom_range(0, 1));
         bus.word_data_i          = $urandom;
         bus.core_ready_i         = ($urandom_range(0, 3) == 0);
         bus.core_msg_out_valid_i = ($urandom_range(0, 4) == 0);
         bus.core_msg_output_i    = {$urandom, $urandom, $urandom, $urandom};
         bus.hash_ack_i           = ($urandom_range(0, 2) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
